stdp_update_scheduler: RTL and testbench

STDP_UPDATE_SCHEDULER -- requirements
Module: stdp_update_scheduler

---
 rtl/stdp_pkg.sv | 19 +
 rtl/stdp_rr_arbiter.sv | 29 ++
 rtl/stdp_update_scheduler.sv | 111 +++++++++++
 tb/tb_stdp_update_scheduler.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/stdp_pkg.sv
// Shared definitions for the STDP weight-update scheduler: FSM encoding and
// default parameter values.
package stdp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_APPLY = 2'd2
  } state_t;

  localparam int STDP_N_SYN   = 4;
  localparam int STDP_W_W     = 8;
  localparam int STDP_DT_W    = 4;
  localparam int STDP_A_PLUS  = 16;
  localparam int STDP_A_MINUS = 12;
  localparam int STDP_WINDOW  = 8;
  localparam int STDP_W_INIT  = 128;

endpackage

// File: rtl/stdp_rr_arbiter.sv
// Combinational round-robin arbiter: searches from last+1 upward (wrapping)
// and returns the first requesting index.
module stdp_rr_arbiter #(
  parameter int N_SYN = 4,
  parameter int IW    = $clog2(N_SYN)
) (
  input  logic [N_SYN-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [IW-1:0]    grant_idx,
  output logic             grant_vld
);

  logic [IW-1:0] cand;

  // N_SYN is a power of two, so the IW-bit add wraps naturally.
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int i = 1; i <= N_SYN; i++) begin
      cand = last + IW'(i);
      if (!grant_vld && req[cand]) begin
        grant_idx = cand;
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stdp_update_scheduler.sv
// Serialises per-synapse STDP update requests through a shared
// IDLE -> CALC -> APPLY datapath with saturating weight arithmetic.
module stdp_update_scheduler
  import stdp_pkg::*;
#(
  parameter int N_SYN   = STDP_N_SYN,
  parameter int W_W     = STDP_W_W,
  parameter int DT_W    = STDP_DT_W,
  parameter int A_PLUS  = STDP_A_PLUS,
  parameter int A_MINUS = STDP_A_MINUS,
  parameter int WINDOW  = STDP_WINDOW,
  parameter int W_INIT  = STDP_W_INIT,
  parameter int IW      = $clog2(N_SYN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_SYN-1:0]      req,
  input  logic [N_SYN-1:0]      ltp,
  input  logic [N_SYN*DT_W-1:0] dt,
  output logic [N_SYN-1:0]      ack,
  output logic                  busy,
  output logic                  upd_valid,
  output logic [IW-1:0]         upd_idx,
  output logic [W_W-1:0]        upd_weight,
  output logic [N_SYN*W_W-1:0]  weights
);

  state_t         state;
  logic [IW-1:0]  last;
  logic [IW-1:0]  gnt_idx;
  logic           gnt_vld;
  logic [IW-1:0]  idx_p0;
  logic           ltp_p0;
  logic [DT_W-1:0] dt_p0;
  logic [W_W-1:0] delta_p1;
  logic [W_W-1:0] new_w;
  logic [W_W-1:0] w_mem [N_SYN];

  function automatic logic [W_W-1:0] calc_delta(input logic l,
                                                input logic [DT_W-1:0] d);
    int amp;
    amp = l ? A_PLUS : A_MINUS;
    if (int'(d) >= WINDOW) return '0;
    return W_W'(amp >> d);
  endfunction

  function automatic logic [W_W-1:0] sat_apply(input logic [W_W-1:0] w,
                                               input logic [W_W-1:0] d,
                                               input logic l);
    logic [W_W:0] sum;
    sum = {1'b0, w} + {1'b0, d};
    if (l) return sum[W_W] ? '1 : sum[W_W-1:0];
    return (d > w) ? '0 : (w - d);
  endfunction

  stdp_rr_arbiter #(.N_SYN(N_SYN), .IW(IW)) u_arb (
    .req       (req),
    .last      (last),
    .grant_idx (gnt_idx),
    .grant_vld (gnt_vld)
  );

  // Control and weight store: reset aborts any transaction before its write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      last  <= IW'(N_SYN - 1);
      for (int i = 0; i < N_SYN; i++) w_mem[i] <= W_W'(W_INIT);
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_vld) begin
            state <= ST_CALC;
            last  <= gnt_idx;
          end
        end
        ST_CALC:  state <= ST_APPLY;
        ST_APPLY: begin
          w_mem[idx_p0] <= new_w;
          state         <= ST_IDLE;
        end
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Stage p0: latch the granted request; inputs are ignored after this edge.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && gnt_vld) begin
      idx_p0 <= gnt_idx;
      ltp_p0 <= ltp[gnt_idx];
      dt_p0  <= dt[gnt_idx*DT_W +: DT_W];
    end
    // Stage p1: delta from the latched direction and dt
    if (state == ST_CALC) delta_p1 <= calc_delta(ltp_p0, dt_p0);
  end

  always_comb begin
    new_w      = sat_apply(w_mem[idx_p0], delta_p1, ltp_p0);
    busy       = (state != ST_IDLE);
    upd_valid  = (state == ST_APPLY);
    upd_idx    = upd_valid ? idx_p0 : '0;
    upd_weight = upd_valid ? new_w : '0;
    ack        = upd_valid ? (N_SYN'(1) << idx_p0) : '0;
  end

  for (genvar g = 0; g < N_SYN; g++) begin : g_flat
    assign weights[g*W_W +: W_W] = w_mem[g];
  end

endmodule

// File: tb/tb_stdp_update_scheduler.sv
// Directed bench for stdp_update_scheduler with hand-computed expectations.
module tb_stdp_update_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  ltp;
  logic [15:0] dt;
  logic [3:0]  ack;
  logic        busy;
  logic        upd_valid;
  logic [1:0]  upd_idx;
  logic [7:0]  upd_weight;
  logic [31:0] weights;

  int n_cmp;
  int n_err;

  stdp_update_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .ltp        (ltp),
    .dt         (dt),
    .ack        (ack),
    .busy       (busy),
    .upd_valid  (upd_valid),
    .upd_idx    (upd_idx),
    .upd_weight (upd_weight),
    .weights    (weights)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One isolated update on synapse i; checks CALC, APPLY and the write-back.
  task automatic upd(input int i, input logic l, input logic [3:0] d,
                     input logic [7:0] exp_w, input string tag);
    @(negedge clk);
    req = 4'(1) << i;
    ltp = 4'(l) << i;
    dt  = 16'(d) << (i * 4);
    @(negedge clk);
    chk({tag, "_calc_busy"}, 64'(busy), 64'd1);
    chk({tag, "_calc_ack"}, 64'(ack), 64'd0);
    @(negedge clk);
    chk({tag, "_ack"}, 64'(ack), 64'(4'(1) << i));
    chk({tag, "_vld"}, 64'(upd_valid), 64'd1);
    chk({tag, "_idx"}, 64'(upd_idx), 64'(i));
    chk({tag, "_wt"}, 64'(upd_weight), 64'(exp_w));
    req = 4'd0;
    @(negedge clk);
    chk({tag, "_stored"}, 64'(weights[i*8 +: 8]), 64'(exp_w));
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    req = 4'd0;
    ltp = 4'd0;
    dt  = 16'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_vld", 64'(upd_valid), 64'd0);
    chk("rst_idx", 64'(upd_idx), 64'd0);
    chk("rst_wt", 64'(upd_weight), 64'd0);
    chk("rst_weights", 64'(weights), 64'h8080_8080);
    rst = 1'b0;

    // LTP dt=0 on synapse 0: 128+16
    upd(0, 1'b1, 4'd0, 8'd144, "ltp0");
    // LTD dt=2 on synapse 1: 128-(12>>2)
    upd(1, 1'b0, 4'd2, 8'd125, "ltd1");

    // Synapse 2 up to 250, then saturate at 255
    for (int k = 0; k < 7; k++) upd(2, 1'b1, 4'd0, 8'(128 + 16 * (k + 1)), "pre2");
    upd(2, 1'b1, 4'd1, 8'd248, "pre2b");
    upd(2, 1'b1, 4'd3, 8'd250, "pre2c");
    upd(2, 1'b1, 4'd0, 8'd255, "sat_hi");

    // Synapse 3 outside the window: completes with no change
    upd(3, 1'b1, 4'd9, 8'd128, "win3");

    // Synapse 2 down to 5, then floor at 0
    for (int k = 0; k < 20; k++) upd(2, 1'b0, 4'd0, 8'(255 - 12 * (k + 1)), "dn2");
    upd(2, 1'b0, 4'd1, 8'd9, "dn2b");
    upd(2, 1'b0, 4'd2, 8'd6, "dn2c");
    upd(2, 1'b0, 4'd3, 8'd5, "dn2d");
    upd(2, 1'b0, 4'd0, 8'd0, "sat_lo");
    chk("weights_a", 64'(weights), 64'h8000_7D90);

    // All four requesting from reset: order 0,1,2,3 every 3 cycles
    @(negedge clk);
    rst = 1'b1;
    req = 4'hF;
    ltp = 4'hF;
    dt  = 16'd0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c % 3 == 2) chk($sformatf("rr4_ack_c%0d", c), 64'(ack), 64'(4'(1) << ((c - 2) / 3)));
      else            chk($sformatf("rr4_ack_c%0d", c), 64'(ack), 64'd0);
    end
    chk("rr4_weights", 64'(weights), 64'h9090_9090);
    req = 4'b1001;
    for (int c = 13; c <= 18; c++) begin
      @(negedge clk);
      if (c == 14)      chk("rr2_ack_0", 64'(ack), 64'b0001);
      else if (c == 17) chk("rr2_ack_3", 64'(ack), 64'b1000);
      else              chk($sformatf("rr2_ack_c%0d", c), 64'(ack), 64'd0);
      if (c == 17) chk("rr2_idx_3", 64'(upd_idx), 64'd3);
    end
    req = 4'd0;
    chk("rr2_weights", 64'(weights), 64'hA090_90A0);

    // Reset while in CALC aborts the transaction
    @(negedge clk);
    req = 4'b0010;
    ltp = 4'b0010;
    dt  = 16'd0;
    @(negedge clk);
    chk("abort_calc_busy", 64'(busy), 64'd1);
    req = 4'd0;
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ack", 64'(ack), 64'd0);
    chk("abort_weights", 64'(weights), 64'h8080_8080);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("abort_noack_%0d", c), 64'({ack, upd_valid, busy}), 64'd0);
    end
    chk("abort_final", 64'(weights), 64'h8080_8080);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
